// File: rtl/exu_mdu.sv
// exu_mdu: iterative RV32M/RV64M-style multiply/divide unit.
//   One radix-2 step per cycle (shift-add multiply, restoring divide) on
//   operand magnitudes, sign correction folded into the final step.
//   Divide-by-zero and signed overflow bypass the iteration and complete
//   in the accepting cycle.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        request handshake (ready only when idle)
//   in_op                    funct3: MUL MULH MULHSU MULHU DIV DIVU REM REMU
//   in_rs1_data/in_rs2_data  operands A and B
//   in_tag                   destination tag, returned on out_tag
//   flush                    abandons any in-flight or completed operation
//   out_valid/out_ready      result handshake
//   out_wdata, out_tag       result (zero while out_valid is low) and tag
//   busy                     operation in progress or result pending
module exu_mdu #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [XLEN-1:0]  in_rs1_data,
    input  logic [XLEN-1:0]  in_rs2_data,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_wdata,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int unsigned     CW       = $clog2(XLEN);
    localparam logic [CW-1:0]   LAST     = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [2:0]      op_q;
    logic [XLEN-1:0] m;       // multiplicand (mul) or divisor (div) magnitude
    logic [XLEN-1:0] acc_hi;  // product high half / partial remainder
    logic [XLEN-1:0] acc_lo;  // multiplier bits / dividend bits, quotient shifts in
    logic            neg_q;   // negate product or quotient
    logic            neg_r;   // negate remainder

    // Request decode
    logic            in_is_div, a_signed, b_signed, a_neg, b_neg;
    logic            div_zero, div_ovf;
    logic [XLEN-1:0] a_mag, b_mag, special_res;

    // One iteration step and final sign correction
    logic [XLEN:0]     mul_sum, div_rem, div_diff;
    logic [XLEN-1:0]   hi_n, lo_n;
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, final_res;

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    always_comb begin
        in_is_div = in_op[2];
        // MUL is treated as signed x signed; its low half is sign-agnostic.
        a_signed  = in_is_div ? ~in_op[0] : (in_op[1:0] != 2'b11);
        b_signed  = in_is_div ? ~in_op[0] : ~in_op[1];
        a_neg     = a_signed & in_rs1_data[XLEN-1];
        b_neg     = b_signed & in_rs2_data[XLEN-1];
        a_mag     = a_neg ? -in_rs1_data : in_rs1_data;
        b_mag     = b_neg ? -in_rs2_data : in_rs2_data;
        div_zero  = in_is_div && (in_rs2_data == '0);
        div_ovf   = in_is_div && !in_op[0] && (in_rs1_data == MOST_NEG)
                    && (in_rs2_data == '1);
        if (div_zero)
            special_res = in_op[1] ? in_rs1_data : '1;
        else
            special_res = in_op[1] ? '0 : MOST_NEG;
    end

    always_comb begin
        mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, m} : '0);
        div_rem  = {acc_hi, acc_lo[XLEN-1]};
        div_diff = div_rem - {1'b0, m};
        if (op_q[2]) begin
            // Borrow out (top bit) means the trial subtraction is undone.
            hi_n = div_diff[XLEN] ? div_rem[XLEN-1:0] : div_diff[XLEN-1:0];
            lo_n = {acc_lo[XLEN-2:0], ~div_diff[XLEN]};
        end else begin
            hi_n = mul_sum[XLEN:1];
            lo_n = {mul_sum[0], acc_lo[XLEN-1:1]};
        end
        prod     = {hi_n, lo_n};
        prod_fix = neg_q ? -prod : prod;
        quo_fix  = neg_q ? -lo_n : lo_n;
        rem_fix  = neg_r ? -hi_n : hi_n;
        if (op_q[2])
            final_res = op_q[1] ? rem_fix : quo_fix;
        else if (op_q[1:0] == 2'b00)
            final_res = prod_fix[XLEN-1:0];
        else
            final_res = prod_fix[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            op_q      <= '0;
            m         <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            out_valid <= 1'b0;
            out_wdata <= '0;
            out_tag   <= '0;
        end else if (flush) begin
            state     <= IDLE;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_q    <= in_op;
                        out_tag <= in_tag;
                        cnt     <= '0;
                        if (div_zero || div_ovf) begin
                            out_wdata <= special_res;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            acc_hi <= '0;
                            m      <= in_is_div ? b_mag : a_mag;
                            acc_lo <= in_is_div ? a_mag : b_mag;
                            neg_q  <= a_neg ^ b_neg;
                            neg_r  <= a_neg;
                            state  <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    acc_hi <= hi_n;
                    acc_lo <= lo_n;
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        cnt       <= '0;
                        out_wdata <= final_res;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_wdata <= '0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/exu_mdu.md
EXU_MDU -- requirements
Module: exu_mdu

Interface
REQ-001 Parameter XLEN, default 32: operand and result width; SHALL be even and at least 8.
REQ-002 Parameter TAG_W, default 5: width of the destination tag passed through unchanged.
REQ-003 clk  input  1: single clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1: reset is synchronous and active-high.
REQ-005 in_valid  input  1: request valid.
REQ-006 in_ready  output  1: unit can accept a request.
REQ-007 in_op  input  3: RV M funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-008 in_rs1_data, in_rs2_data  input  XLEN: operand A and operand B.
REQ-009 in_tag  input  TAG_W: destination tag.
REQ-010 flush  input  1: abandons any in-flight operation.
REQ-011 out_valid  output  1: result valid.
REQ-012 out_ready  input  1: consumer accepts the result.
REQ-013 out_wdata  output  XLEN: result.
REQ-014 out_tag  output  TAG_W: tag of the accepted request.
REQ-015 busy  output  1: high in BUSY or DONE.

Function
REQ-016 FSM states SHALL be IDLE, BUSY and DONE; in_ready SHALL equal (state==IDLE).
REQ-017 IDLE with in_valid: the unit SHALL latch op, operands and tag, then go to BUSY, or to DONE for a special case (REQ-022/023).
REQ-018 BUSY: one radix-2 iteration per cycle; a counter runs from 0 to XLEN-1; after iteration XLEN-1 the FSM SHALL go to DONE.
REQ-019 Normal latency: out_valid SHALL rise exactly XLEN+1 rising edges after the accepting edge.
REQ-020 Multiply: the unit SHALL form the 2*XLEN-bit product with shift-add on operand magnitudes, then apply sign correction.
  - MULH: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU: both unsigned.
  - MUL SHALL return product[XLEN-1:0]; MULH/MULHSU/MULHU SHALL return product[2*XLEN-1:XLEN].
REQ-021 Divide: restoring division on magnitudes.
  - Quotient sign SHALL be sign(A) xor sign(B).
  - Remainder sign SHALL be sign(A).
  - DIVU and REMU SHALL treat operands as unsigned.
REQ-022 Divide by zero SHALL take the 1-cycle path.
  - DIV and DIVU SHALL return all ones.
  - REM and REMU SHALL return operand A.
REQ-023 Signed overflow (DIV or REM, A = most-negative, B = -1) SHALL take the 1-cycle path: DIV SHALL return most-negative and REM SHALL return 0.
REQ-024 On the 1-cycle path, out_valid SHALL rise 1 edge after the accepting edge.
REQ-025 DONE: out_valid=1; out_wdata and out_tag SHALL hold stable until the edge where out_ready=1, then the FSM SHALL return to IDLE.
REQ-026 No new request SHALL be accepted in the same cycle as output retirement; the minimum issue interval is 2 cycles for special cases and XLEN+2 cycles otherwise.
REQ-027 flush SHALL move any state to IDLE on the next edge and drop out_valid.
REQ-028 flush SHALL override a simultaneous in_valid, which is not accepted.
REQ-029 flush SHALL override a simultaneous out_ready handshake; that result is considered discarded.
REQ-030 out_wdata SHALL be 0 whenever out_valid=0.
REQ-031 All arithmetic SHALL be XLEN-generic, with no hard-coded 32.

Reset
REQ-032 With rst=1 at an edge, the state SHALL become IDLE and the counter 0.
REQ-033 After that reset edge: out_valid=0, out_wdata=0, out_tag=0, busy=0 and in_ready=1.
REQ-034 rst SHALL take priority over flush and all handshakes, including mid-BUSY and in DONE.
REQ-035 in_ready SHALL be 1 in the first cycle after reset is released.

Verification
REQ-036 XLEN=32: MUL, A=7, B=0xFFFFFFFD, tag 3 -> out_valid on edge 33 after accept; out_wdata=0xFFFFFFEB, out_tag=3.
REQ-037 MULH, A=B=0x80000000 -> 0x40000000.
REQ-038 MULHU, A=B=0xFFFFFFFF -> 0xFFFFFFFE.
REQ-039 MULHSU, A=0xFFFFFFFF, B=2 -> 0xFFFFFFFF.
REQ-040 DIV, A=-7, B=2 -> 0xFFFFFFFD; REM of the same operands -> 0xFFFFFFFF; each at 33 edges.
REQ-041 Special cases, each with out_valid after 1 edge:
  - DIVU, A=0x1234, B=0 -> 0xFFFFFFFF.
  - REMU, same operands -> 0x1234.
  - DIV, A=0x80000000, B=0xFFFFFFFF -> 0x80000000.
  - REM, same operands -> 0.
REQ-042 Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_wdata and out_tag stable, in_ready=0; raise out_ready -> IDLE on the next edge.
REQ-043 Flush or reset at iteration 15 of a DIV -> IDLE on the next edge with out_valid=0; a following MUL 3*5 -> 15 at normal latency.
REQ-044 XLEN=8 build: MUL, A=0x10, B=0x10 -> 0x00; MULHU -> 0x01; latency 9 edges.
